// File: rtl/multi_seq_detector.sv
// Multi-channel serial pattern detector: each channel matches one programmable PATTERN,
// with overlap/non-overlap mode and back-to-back match flagging. Macro SEQ_MATCH_CNT_EN adds
// per-channel saturating match counters.

module msd_lane #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_i,
  input  logic             vld_i,
  input  logic             ovl_i,
  input  logic             clr_i,
  output logic [1:0]       code_o,
  output logic [CNT_W-1:0] cnt_o
);
  localparam int             FW   = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]  FULL = FW'(PAT_LEN);

  typedef enum logic {FILL = 1'b0, ARMED = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [PAT_LEN-1:0] hist_q, hist_d, shifted;
  logic [FW-1:0]      fcnt_q, fcnt_d, fcnt_inc;
  logic               lm_q, lm_d;
  logic               match;
  logic [1:0]         code_q, code_d;

  always_comb begin
    shifted  = {hist_q[PAT_LEN-2:0], bit_i};
    fcnt_inc = (fcnt_q == FULL) ? FULL : fcnt_q + 1'b1;
    match    = vld_i && (shifted == PATTERN) && (fcnt_inc == FULL);

    hist_d = hist_q;
    fcnt_d = fcnt_q;
    lm_d   = lm_q;
    if (vld_i) begin
      hist_d = shifted;
      lm_d   = match;
      // Non-overlap mode restarts the fill so the next match needs PAT_LEN fresh bits.
      fcnt_d = (match && !ovl_i) ? '0 : fcnt_inc;
    end

    state_d = (fcnt_d == FULL) ? ARMED : FILL;

    code_d = {1'b0, state_d == ARMED};
    if (match) code_d = {1'b1, lm_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      hist_q  <= '0;
      fcnt_q  <= '0;
      lm_q    <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fcnt_q  <= fcnt_d;
      lm_q    <= lm_d;
      code_q  <= code_d;
    end
  end

  assign code_o = code_q;

`ifdef SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A clear coinciding with a match keeps that match, so the count restarts at 1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                         cnt_d = match ? CNT_W'(1) : '0;
    else if (match && (cnt_q != '1))   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_i;
  assign cnt_o      = '0;
`endif

endmodule

module multi_seq_detector #(
  parameter int                 CHANNELS = 5,
  parameter int                 PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PATTERN  = 4'b1010,
  parameter int                 CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       inp,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic                      mode_ovl,
  input  logic                      cnt_clr,
  output logic [2*CHANNELS-1:0]     out,
  output logic [CNT_W*CHANNELS-1:0] match_cnt
);
  logic [CHANNELS-1:0][1:0]       code;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    msd_lane #(
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN),
      .CNT_W   (CNT_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .bit_i  (inp[c]),
      .vld_i  (in_valid[c]),
      .ovl_i  (mode_ovl),
      .clr_i  (cnt_clr),
      .code_o (code[c]),
      .cnt_o  (cnt[c])
    );
  end

  assign out       = code;
  assign match_cnt = cnt;

endmodule

// File: tb/tb_multi_seq_detector.sv
// Directed bench for multi_seq_detector: three instances (default pattern, all-ones pattern,
// 2-bit counters) share stimulus; expected codes are queued at drive time and popped after the edge.

module tb_multi_seq_detector;
`ifdef SEQ_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] inp, in_valid;
  logic       mode_ovl, cnt_clr;
  logic [9:0]  out_def, out_ones, out_c2;
  logic [39:0] cnt_def, cnt_ones;
  logic [9:0]  cnt_c2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         dut;
    int         ch;
    logic [1:0] code;
    string      tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  multi_seq_detector u_def (
    .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .mode_ovl(mode_ovl),
    .cnt_clr(cnt_clr), .out(out_def), .match_cnt(cnt_def)
  );

  multi_seq_detector #(.PATTERN(4'b1111)) u_ones (
    .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .mode_ovl(mode_ovl),
    .cnt_clr(cnt_clr), .out(out_ones), .match_cnt(cnt_ones)
  );

  multi_seq_detector #(.CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .mode_ovl(mode_ovl),
    .cnt_clr(cnt_clr), .out(out_c2), .match_cnt(cnt_c2)
  );

  function automatic logic [1:0] code_of(int d, int c);
    case (d)
      0:       return out_def[2*c +: 2];
      1:       return out_ones[2*c +: 2];
      default: return out_c2[2*c +: 2];
    endcase
  endfunction

  task automatic expect_code(input int d, input int c, input logic [1:0] code, input string tag);
    exp_t e;
    e.dut = d; e.ch = c; e.code = code; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic step(input logic [4:0] v, input logic [4:0] d);
    exp_t       e;
    logic [1:0] obs;
    in_valid = v;
    inp      = d;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = code_of(e.dut, e.ch);
      checks++;
      assert (obs === e.code) else begin
        errors++;
        $error("FAIL %s dut%0d ch%0d: observed %b expected %b", e.tag, e.dut, e.ch, obs, e.code);
      end
    end
  endtask

  task automatic check_cnt(input logic [39:0] obs, input logic [39:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(5'b0, 5'b0);
    rst = 1'b0;
  endtask

  logic [1:0] codes2 [6];
  logic [1:0] codes3 [6];
  logic [1:0] codes4 [7];
  logic [1:0] codes5 [4];
  logic [5:0] bits6;
  int         nmatch;

  initial begin
    rst = 1'b1; inp = '0; in_valid = '0; mode_ovl = 1'b1; cnt_clr = 1'b0;

    // Reset and idle hold
    step(5'b0, 5'b0);
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 5; c++) expect_code(d, c, 2'b00, "reset_out");
    step(5'b0, 5'b0);
    check_cnt(cnt_def, 40'h0, "reset_cnt_def");
    check_cnt({30'h0, cnt_c2}, 40'h0, "reset_cnt_c2");
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 5; c++) expect_code(0, c, 2'b00, "idle_out");
      step(5'b0, 5'b0);
    end
    check_cnt(cnt_def, 40'h0, "idle_cnt_def");

    // Overlap mode, ch0 1,0,1,0,1,0
    mode_ovl = 1'b1;
    bits6  = 6'b101010;
    codes2 = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
    for (int k = 0; k < 6; k++) begin
      expect_code(0, 0, codes2[k], "ovl_1010");
      step(5'b00001, {4'b0, bits6[5-k]});
    end
    check_cnt({32'h0, cnt_def[7:0]}, CNT_ON ? 40'd2 : 40'd0, "ovl_cnt0");

    // Non-overlap mode, same stream
    do_reset();
    mode_ovl = 1'b0;
    codes3 = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    for (int k = 0; k < 6; k++) begin
      expect_code(0, 0, codes3[k], "novl_1010");
      step(5'b00001, {4'b0, bits6[5-k]});
    end
    check_cnt({32'h0, cnt_def[7:0]}, CNT_ON ? 40'd1 : 40'd0, "novl_cnt0");

    // All-ones pattern on ch2, valid gap after bit 5
    do_reset();
    mode_ovl = 1'b1;
    codes4 = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b01, 2'b11};
    for (int k = 0; k < 7; k++) begin
      expect_code(1, 2, codes4[k], "ones_gap");
      step((k == 5) ? 5'b00000 : 5'b00100, 5'b00100);
    end

    // Mid-pattern reset on ch1
    do_reset();
    for (int k = 0; k < 3; k++) begin
      expect_code(0, 1, 2'b00, "pre_rst");
      step(5'b00010, (k == 1) ? 5'b0 : 5'b00010);
    end
    rst = 1'b1;
    for (int c = 0; c < 5; c++) expect_code(0, c, 2'b00, "mid_rst");
    step(5'b00010, 5'b00000);
    rst = 1'b0;
    codes5 = '{2'b00, 2'b00, 2'b00, 2'b10};
    for (int k = 0; k < 4; k++) begin
      expect_code(0, 1, codes5[k], "post_rst");
      step(5'b00010, (k % 2 == 0) ? 5'b00010 : 5'b00000);
    end

    // Simultaneous match on every channel
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) for (int c = 0; c < 5; c++) expect_code(0, c, 2'b10, "all_ch_match");
      step(5'b11111, (k % 2 == 0) ? 5'b11111 : 5'b00000);
    end

    // Saturating 2-bit counter on ch3, then clear with and without a match
    do_reset();
    mode_ovl = 1'b1;
    nmatch   = 0;
    for (int k = 0; k < 12; k++) begin
      expect_code(2, 3, (k < 3) ? 2'b00 : ((k % 2 == 1) ? 2'b10 : 2'b01), "c2_stream");
      step(5'b01000, (k % 2 == 0) ? 5'b01000 : 5'b00000);
      if (k >= 3 && k % 2 == 1) begin
        nmatch++;
        check_cnt({38'h0, cnt_c2[7:6]},
                  CNT_ON ? 40'((nmatch > 3) ? 3 : nmatch) : 40'd0, "c2_sat");
      end
    end
    expect_code(2, 3, 2'b01, "c2_pre_clr");
    step(5'b01000, 5'b01000);
    cnt_clr = 1'b1;
    expect_code(2, 3, 2'b10, "c2_clr_match");
    step(5'b01000, 5'b00000);
    check_cnt({38'h0, cnt_c2[7:6]}, CNT_ON ? 40'd1 : 40'd0, "c2_clr_match_cnt");
    expect_code(2, 3, 2'b01, "c2_clr_idle");
    step(5'b00000, 5'b00000);
    cnt_clr = 1'b0;
    check_cnt({38'h0, cnt_c2[7:6]}, 40'd0, "c2_clr_only_cnt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
